// File: rtl/cap_rank_sorter_if.sv
// cap_rank_sorter_if: voltage load, comparator and sorted-index signals of the rank sorter
interface cap_rank_sorter_if #(
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int IDXW = $clog2(N)
);
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [W-1:0]    cmp_vi;
  logic [W-1:0]    cmp_vj;
  logic            cmp_cij;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            busy;
  modport master (
    output start, in_valid, in_data, cmp_cij, out_ready,
    input  in_ready, cmp_vi, cmp_vj, out_valid, out_idx, out_last, busy
  );
  modport slave (
    input  start, in_valid, in_data, cmp_cij, out_ready,
    output in_ready, cmp_vi, cmp_vj, out_valid, out_idx, out_last, busy
  );
endinterface

// File: rtl/cap_rank_sorter.sv
// cap_rank_sorter: ranks N capacitor voltages via an external pairwise comparator and
// streams their indices highest voltage first
module cap_rank_sorter #(
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int IDXW = $clog2(N)
) (
  input logic             clk,
  input logic             rst,
  cap_rank_sorter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, COMPARE, PERM, OUTPUT} state_t;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [IDXW-1:0] PENULT = IDXW'(N - 2);
  state_t          r_state;
  logic [W-1:0]    r_v    [N];
  logic [IDXW-1:0] r_rank [N];
  logic [IDXW-1:0] r_slot [N];
  logic [IDXW-1:0] r_cnt, r_i, r_j, r_k, r_p;
  logic            r_in_ready, r_out_valid, r_out_last, r_busy;
  logic            w_eq, w_inc;
  assign bus.cmp_vi    = r_v[r_i];
  assign bus.cmp_vj    = r_v[r_j];
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_idx   = r_slot[r_p];
  assign bus.busy      = r_busy;
  // equal magnitudes resolve toward the lower index so ranks form a permutation
  assign w_eq  = r_v[r_i][W-2:0] == r_v[r_j][W-2:0];
  assign w_inc = (r_i != r_j) && (bus.cmp_cij || (w_eq && r_j < r_i));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_p         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      for (int n = 0; n < N; n++) begin
        r_v[n]    <= '0;
        r_rank[n] <= '0;
        r_slot[n] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_state    <= LOAD;
          r_cnt      <= '0;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b1;
          for (int n = 0; n < N; n++) r_rank[n] <= '0;
        end
        LOAD: if (bus.in_valid && r_in_ready) begin
          r_v[r_cnt] <= bus.in_data;
          r_cnt      <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state    <= COMPARE;
            r_in_ready <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
          end
        end
        COMPARE: begin
          if (w_inc) r_rank[r_i] <= r_rank[r_i] + 1'b1;
          r_j <= (r_j == LAST) ? '0 : r_j + 1'b1;
          if (r_j == LAST) r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
          if (r_i == LAST && r_j == LAST) begin
            r_state <= PERM;
            r_k     <= '0;
          end
        end
        PERM: begin
          r_slot[r_rank[r_k]] <= r_k;
          r_k <= r_k + 1'b1;
          if (r_k == LAST) begin
            r_state     <= OUTPUT;
            r_p         <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
          end
        end
        OUTPUT: if (bus.out_ready) begin
          if (r_out_last) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_p        <= r_p + 1'b1;
            r_out_last <= r_p == PENULT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cap_rank_sorter.sv
// tb_cap_rank_sorter: table-driven and randomized checks of the capacitor rank sorter
module tb_cap_rank_sorter;
  localparam int N = 8;
  typedef struct {
    logic [31:0] v[N];
    logic [2:0]  e[N];
    bit          gap;
    int          stall;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  vec_t tbl[4];
  vec_t rv;
  cap_rank_sorter_if #(.N(N), .W(32)) bus();
  cap_rank_sorter #(.N(N), .W(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  // comparator: Cij = |Vi| < |Vj|, sign bit ignored
  assign bus.cmp_cij = bus.cmp_vi[30:0] < bus.cmp_vj[30:0];
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // reference order: repeatedly pick the largest unused magnitude, lowest index on ties
  function automatic void model(inout vec_t t);
    bit used[N];
    int best;
    for (int i = 0; i < N; i++) used[i] = 1'b0;
    for (int pos = 0; pos < N; pos++) begin
      best = -1;
      for (int i = 0; i < N; i++)
        if (!used[i] && (best < 0 || t.v[i][30:0] > t.v[best][30:0])) best = i;
      used[best] = 1'b1;
      t.e[pos] = 3'(best);
    end
  endfunction

  task automatic do_start();
    bus.start = 1'b1;
    cyc = 0;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("in_ready_after_start", 32'(bus.in_ready), 1);
  endtask

  task automatic load(input vec_t t);
    int n = 0;
    int g = 0;
    bit val, acc;
    while (n < N && g < 100) begin
      val = t.gap ? (g[0] == 1'b0) : 1'b1;
      bus.in_valid = val;
      bus.in_data = t.v[n];
      acc = val && bus.in_ready;
      tick();
      g++;
      if (acc) n++;
    end
    bus.in_valid = 1'b0;
    chk("load_beats", 32'(n), N);
    chk("in_ready_after_load", 32'(bus.in_ready), 0);
  endtask

  task automatic collect(input vec_t t, input bit lat);
    int g = 0;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && g < 300) begin
      tick();
      g++;
    end
    chk("first_out_valid", 32'(bus.out_valid), 1);
    if (lat) chk("latency_cycles", 32'(cyc), 81);
    for (int s = 0; s < t.stall; s++) begin
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_idx", 32'(bus.out_idx), 32'(t.e[0]));
      chk("stall_last", 32'(bus.out_last), 0);
      tick();
    end
    for (int p = 0; p < N; p++) begin
      bus.out_ready = 1'b1;
      chk("out_valid", 32'(bus.out_valid), 1);
      chk("out_idx", 32'(bus.out_idx), 32'(t.e[p]));
      chk("out_last", 32'(bus.out_last), 32'(p == N - 1));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("valid_drop", 32'(bus.out_valid), 0);
    chk("busy_drop", 32'(bus.busy), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({nm, "_out_idx"}, 32'(bus.out_idx), 0);
    chk({nm, "_out_last"}, 32'(bus.out_last), 0);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
    chk({nm, "_cmp_vi"}, bus.cmp_vi, 0);
    chk({nm, "_cmp_vj"}, bus.cmp_vj, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    tbl[0].v = '{32'h40E00000, 32'h3F800000, 32'h41B80000, 32'h41200000,
                 32'h3F800001, 32'h40000000, 32'h3F000000, 32'h40400000};
    tbl[0].e = '{3'd2, 3'd3, 3'd0, 3'd7, 3'd5, 3'd4, 3'd1, 3'd6};
    tbl[0].gap = 1'b0;
    tbl[0].stall = 0;
    tbl[1].v = '{default: 32'h3F800000};
    tbl[1].e = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[1].gap = 1'b0;
    tbl[1].stall = 0;
    tbl[2].v = '{default: 32'h3F800000};
    tbl[2].v[0] = 32'hC0000000;
    tbl[2].e = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[2].gap = 1'b0;
    tbl[2].stall = 0;
    tbl[3] = tbl[0];
    tbl[3].gap = 1'b1;
    tbl[3].stall = 5;
    for (int t = 0; t < 4; t++) begin
      do_start();
      load(tbl[t]);
      collect(tbl[t], t == 0);
    end
    // reset mid-COMPARE, after an ignored start pulse
    do_start();
    load(tbl[0]);
    while (cyc < 20) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_ignored_in_ready", 32'(bus.in_ready), 0);
    chk("start_ignored_busy", 32'(bus.busy), 1);
    while (cyc < 30) tick();
    rst = 1'b1;
    #1;
    chk_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    load(tbl[0]);
    collect(tbl[0], 1'b1);
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: rv.v[i] = (i > 0) ? rv.v[$urandom_range(0, i - 1)] : $urandom;
          1: rv.v[i] = (i > 0) ? (rv.v[$urandom_range(0, i - 1)] ^ 32'h80000000) : $urandom;
          default: rv.v[i] = $urandom;
        endcase
      end
      rv.gap = 1'($urandom_range(0, 1));
      rv.stall = $urandom_range(0, 3);
      model(rv);
      do_start();
      load(rv);
      collect(rv, !rv.gap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
